// File: rtl/mem_responder_if.sv
// Request/response bundle between a memory initiator and mem_responder.
// rsp_err exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [15:0]       rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              busy;
    logic [3:0]        inflight;
`ifdef MEM_ALIGN_CHECK_EN
    logic              rsp_err;
`endif

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        input  rsp_err,
`endif
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, busy, inflight
    );

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        output rsp_err,
`endif
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_addr, busy, inflight
    );
endinterface

// File: rtl/mem_responder.sv
// Pipelined 16-bit word memory: reads return LATENCY cycles after acceptance, one request per cycle,
// never backpressures. MEM_ALIGN_CHECK_EN adds rsp_err for odd byte addresses.
module mem_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_responder_if.slave     bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] widx;
    logic [ADDR_W-1:0]     addr_aligned;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  misalign;

    logic [LATENCY-1:0]    stg_vld;
    logic [LATENCY-1:0]    stg_err;
    logic [15:0]           stg_dat  [LATENCY];
    logic [ADDR_W-1:0]     stg_addr [LATENCY];
    logic [3:0]            inflight_q;
    logic [3:0]            inflight_nxt;
    logic                  busy_q;

    assign widx         = bus.req_addr[DEPTH_LOG2:1];
    assign addr_aligned = bus.req_addr & ~ADDR_W'(1);
    assign accept       = bus.req_valid & ~rst;
    assign rd_acc       = accept & ~bus.req_wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign     = bus.req_addr[0];
`else
    assign misalign     = 1'b0;
`endif

    // Misaligned writes never touch the array; they only produce an error pulse.
    assign wr_acc       = accept & bus.req_wr & ~misalign;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[widx] <= bus.req_wdata;
        end
    end

    assign inflight_nxt = inflight_q + 4'(rd_acc) - 4'(stg_vld[LATENCY-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld    <= '0;
            stg_err    <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_dat[i]  <= '0;
                stg_addr[i] <= '0;
            end
        end else begin
            stg_vld[0]  <= rd_acc;
            stg_err[0]  <= accept & misalign;
            stg_dat[0]  <= rd_acc ? mem[widx] : 16'h0000;
            stg_addr[0] <= rd_acc ? addr_aligned : '0;
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i]  <= stg_vld[i-1];
                stg_err[i]  <= stg_err[i-1];
                stg_dat[i]  <= stg_dat[i-1];
                stg_addr[i] <= stg_addr[i-1];
            end
            inflight_q <= inflight_nxt;
            busy_q     <= (inflight_nxt != 4'd0);
        end
    end

    assign bus.req_ready = ~rst;
    assign bus.rsp_valid = stg_vld[LATENCY-1];
    assign bus.rsp_data  = stg_dat[LATENCY-1];
    assign bus.rsp_addr  = stg_addr[LATENCY-1];
    assign bus.inflight  = inflight_q;
    assign bus.busy      = busy_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign bus.rsp_err   = stg_err[LATENCY-1];
`else
    logic unused_err;
    assign unused_err    = ^stg_err;
`endif
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle, fully pipelined 16-bit word memory.
- Acts as the responder end of the pipeline's memory request interface: the fetch stage, the MEM stage, or a cache fill engine issues requests, and this block returns read data a fixed LATENCY cycles later.
- Accepts one request per cycle. Returns read data tagged with its address so an initiator can match fill beats.

Parameters:
- LATENCY, 4, cycles from request acceptance edge to rsp_valid; legal range 1..8.
- ADDR_W, 16, byte-address width; word index is req_addr[ADDR_W-1:1].
- DEPTH_LOG2, 15, log2 of the number of 16-bit words stored; must be <= ADDR_W-1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- req_valid, input, 1, request present this cycle.
- req_wr, input, 1, 1 = write, 0 = read; qualified by req_valid.
- req_addr, input, ADDR_W, byte address; bit 0 is ignored, bits above DEPTH_LOG2 are ignored (aliasing).
- req_wdata, input, 16, write data.
- req_ready, output, 1, constant 1 outside reset; 0 while rst is high.
- rsp_valid, output, 1, read data valid this cycle.
- rsp_data, output, 16, read data.
- rsp_addr, output, ADDR_W, req_addr of the read being returned, bit 0 forced to 0.
- busy, output, 1, 1 while any read is in flight in the response pipeline.
- inflight, output, 4, count of reads in flight (0..LATENCY).

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0, inflight=0, req_ready=0.
  - All pipeline valid bits are cleared.
  - Memory array contents are not reset.
  - A request presented while rst=1 is dropped, including writes.
- Acceptance: a request is accepted on a rising edge with req_valid=1, req_ready=1 and rst=0.
- Write:
  - mem[word] <= req_wdata on the acceptance edge.
  - No response is generated; rsp_valid is never asserted for writes.
- Read:
  - The array is sampled on the acceptance edge into pipeline stage 1 (valid, data, addr).
  - The stages shift one position per cycle.
  - rsp_valid/rsp_data/rsp_addr reflect stage LATENCY, so they are valid exactly LATENCY cycles after the accepting edge, for exactly one cycle.
  - LATENCY=1 means the response is visible in the cycle after acceptance.
- Ordering:
  - Responses leave in request order.
  - A read accepted N cycles after a write to the same word returns the written data for any N>=1.
  - A read and a write to the same word cannot coexist in one cycle, since a single request port is used.
- Back-to-back reads on consecutive cycles produce rsp_valid on consecutive cycles. There are no bubbles and no backpressure; the initiator must consume every response.
- inflight:
  - Increments on each accepted read.
  - Decrements on each cycle rsp_valid=1.
  - If both happen in the same cycle, it is unchanged.
  - Saturation is impossible by construction; max = LATENCY.
- busy = (inflight != 0), registered consistently with inflight.
- Reset mid-operation: all in-flight reads are discarded and no response appears after rst deasserts. Writes already accepted remain in the array.
- Address wrap: word index = req_addr[DEPTH_LOG2:1]; higher address bits alias onto lower words.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Enabled:
  - Adds output port rsp_err, 1 bit (reset 0).
  - A request with req_addr[0]=1 is flagged misaligned.
  - A misaligned read still returns data for the masked word, with rsp_err=1 in the same cycle as its rsp_valid; the error bit travels down the pipeline.
  - A misaligned write is suppressed: the array is unchanged and rsp_err pulses for one cycle, LATENCY cycles later, with rsp_valid=0.
- Disabled: no rsp_err port; bit 0 is silently ignored for both reads and writes.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=1, wr=1, addr=0x0010, wdata=0xBEEF, then read 0x0010 -> data is not 0xBEEF (write dropped); during reset rsp_valid=0, busy=0, req_ready=0.
- Basic: write 0x1234 to 0x0020, next cycle read 0x0020 -> rsp_valid=1 exactly 4 cycles after the read edge, rsp_data=0x1234, rsp_addr=0x0020, single-cycle pulse.
- Streaming: write 0x00A0..0x00A6 with data 1,2,3,4, then 4 back-to-back reads -> 4 consecutive rsp_valid cycles with data 1,2,3,4 in order; inflight peaks at 4; busy drops the cycle after the last response.
- Mixed: read A, write A=0x5555, read A on 3 consecutive cycles -> first response has the old value, second response 0x5555; a single response slot is skipped where the write was.
- Reset mid-flight: issue 3 reads, assert rst 2 cycles after the first -> no rsp_valid ever appears for them; inflight=0 after reset.
- With MEM_ALIGN_CHECK_EN: write 0x7777 to 0x0031 -> rsp_err pulse 4 cycles later, mem[0x0030] unchanged; read 0x0031 -> rsp_data=mem[0x0030] with rsp_err=1 and rsp_valid=1 together.
